// File: rtl/mips_mem_pkg.sv
// Store op codes, per-entry lane data and the narrowing/alignment helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mips_mem_pkg;

  // Same encoding as the load/immediate extender op codes.
  typedef enum logic [1:0] {
    ST_W   = 2'd0,
    ST_H   = 2'd1,
    ST_B   = 2'd2,
    ST_RSV = 2'd3
  } st_op_e;

  // Lane-replicated write data and byte enables for one store.
  // The entry address lives next to this in the top, because its width follows AW.
  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_lane_t;

  // A word must be 4-byte aligned and a half 2-byte aligned. The reserved op is never legal.
  function automatic logic st_bad(st_op_e op, logic [1:0] lo);
    logic bad;
    case (op)
      ST_W:    bad = (lo != 2'b00);
      ST_H:    bad = lo[0];
      ST_B:    bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Replicate the low bits of the register across every lane. The byte enables then
  // select the lanes that memory actually writes.
  function automatic st_lane_t st_narrow(st_op_e op, logic [1:0] lo, logic [31:0] data);
    st_lane_t r;
    r.wdata = data;
    r.be    = 4'b1111;
    case (op)
      ST_H: begin
        r.wdata = {2{data[15:0]}};
        r.be    = lo[1] ? 4'b1100 : 4'b0011;
      end
      ST_B: begin
        r.wdata = {4{data[7:0]}};
        r.be    = 4'b0001 << lo;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_narrow_buf_if.sv
// Store-issue and DM-write-port signal bundle for the store narrowing buffer.
// Latency: n/a (wires only).
// Backpressure: st_ready toward MEM stage, dm_ack from DM.
// slave = buffer side, master = pipeline/DM side.
//   st_valid/st_ready/st_op/st_addr/st_data/st_err : store request channel
//   dm_req/dm_ack/dm_addr/dm_wdata/dm_be           : DM write port
//   buf_empty/buf_count                            : occupancy status
interface store_narrow_buf_if #(
  parameter int AW    = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_ready;
  logic [1:0]    st_op;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic          st_err;
  logic          dm_req;
  logic          dm_ack;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [3:0]    dm_be;
  logic          buf_empty;
  logic [CW-1:0] buf_count;

  modport slave (
    input  st_valid, st_op, st_addr, st_data, dm_ack,
    output st_ready, st_err, dm_req, dm_addr, dm_wdata, dm_be, buf_empty, buf_count
  );

  modport master (
    output st_valid, st_op, st_addr, st_data, dm_ack,
    input  st_ready, st_err, dm_req, dm_addr, dm_wdata, dm_be, buf_empty, buf_count
  );
endinterface

// File: rtl/fifo_sync.sv
// Generic synchronous FIFO with a registered head word.
// Latency: a push at edge N is visible on head_dat after edge N.
// Backpressure: caller must not push when full or pop when empty.
// Ports: clk, reset_n (async low), push_vld/push_dat, pop_vld, head_dat, full, empty, count.
module fifo_sync #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_vld) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_vld) - CW'(pop_vld);
    // Preload the word that will be at the head after this edge. mem_d already includes
    // this cycle's push, so a push into an empty FIFO appears after one edge. When the
    // FIFO goes empty, head holds its last value.
    if (count_d != '0) begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_dat = head_q;
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/store_narrow_buf.sv
// Narrows MEM-stage stores to byte lanes with enables and queues them for the DM write port.
// Latency: a store accepted at edge N is presented on dm_* after edge N. st_err pulses the cycle after a bad accept.
// Backpressure: st_ready = !full (independent of dm_ack). Entries leave on dm_req && dm_ack.
// Ports: clk, reset_n (async low), bus (store_narrow_buf_if.slave: st_*, dm_*, buf_empty, buf_count).
module store_narrow_buf
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  store_narrow_buf_if.slave     bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Only the word address is stored. dm_addr is always word aligned.
  typedef struct packed {
    logic [AW-3:0] waddr;
    st_lane_t      lane;
  } entry_t;
  localparam int EW = $bits(entry_t);

  st_op_e        op;
  logic          accept, bad, push, pop;
  logic          full, empty;
  logic [CW-1:0] count;
  entry_t        wr_entry, head;
  logic [EW-1:0] head_raw;
  logic          st_err_q, st_err_d;

  assign op     = st_op_e'(bus.st_op);
  assign accept = bus.st_valid && !full;
  assign bad    = st_bad(op, bus.st_addr[1:0]);
  // A bad request completes the handshake but is dropped instead of queued.
  assign push   = accept && !bad;
  assign pop    = !empty && bus.dm_ack;

  always_comb begin
    wr_entry.waddr = bus.st_addr[AW-1:2];
    wr_entry.lane  = st_narrow(op, bus.st_addr[1:0], bus.st_data);
    st_err_d       = accept && bad;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st_err_q <= 1'b0;
    else          st_err_q <= st_err_d;
  end

  fifo_sync #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (push),
    .push_dat (wr_entry),
    .pop_vld  (pop),
    .head_dat (head_raw),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign head          = head_raw;
  assign bus.st_ready  = !full;
  assign bus.st_err    = st_err_q;
  assign bus.dm_req    = !empty;
  assign bus.dm_addr   = {head.waddr, 2'b00};
  assign bus.dm_wdata  = head.lane.wdata;
  // Stale head data may remain visible, but no lane is enabled while empty.
  assign bus.dm_be     = empty ? 4'b0000 : head.lane.be;
  assign bus.buf_empty = empty;
  assign bus.buf_count = count;

endmodule

// File: tb/tb_store_narrow_buf.sv
module tb_store_narrow_buf;
  localparam int DEPTH = 2;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  store_narrow_buf_if #(.AW(AW), .DEPTH(DEPTH)) bus ();
  store_narrow_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t mq[$];
  logic err_exp = 1'b0;
  bit   m_acc, m_bad;

  function automatic bit bad_ref(int op, logic [31:0] a);
    return (op == 3) || (op == 0 && (a % 4) != 0) || (op == 1 && (a % 2) != 0);
  endfunction

  function automatic exp_t narrow_ref(int op, logic [31:0] a, logic [31:0] d);
    exp_t e;
    e.addr = a & 32'hFFFF_FFFC;
    if (op == 0) begin
      e.wdata = d;
      e.be    = 4'hF;
    end else if (op == 1) begin
      e.wdata = d[15:0] * 32'h0001_0001;
      e.be    = ((a % 4) == 2) ? 4'b1100 : 4'b0011;
    end else begin
      e.wdata = {24'd0, d[7:0]} * 32'h0101_0101;
      e.be    = 4'(1 << (a % 4));
    end
    return e;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      err_exp = 1'b0;
    end else begin
      m_acc = bus.st_valid && (mq.size() < DEPTH);
      m_bad = bad_ref(int'(bus.st_op), bus.st_addr);
      if (mq.size() > 0 && bus.dm_ack) void'(mq.pop_front());
      err_exp = m_acc && m_bad;
      if (m_acc && !m_bad) mq.push_back(narrow_ref(int'(bus.st_op), bus.st_addr, bus.st_data));
    end
  end

  // Compare process: outputs are meaningful every cycle.
  always @(negedge clk) begin
    check("m_dm_req",    bus.dm_req,    mq.size() != 0);
    check("m_buf_count", bus.buf_count, mq.size());
    check("m_buf_empty", bus.buf_empty, mq.size() == 0);
    check("m_st_ready",  bus.st_ready,  mq.size() < DEPTH);
    check("m_st_err",    bus.st_err,    err_exp);
    if (mq.size() > 0) begin
      check("m_dm_addr",  bus.dm_addr,  mq[0].addr);
      check("m_dm_wdata", bus.dm_wdata, mq[0].wdata);
      check("m_dm_be",    bus.dm_be,    mq[0].be);
    end else begin
      check("m_dm_be_empty", bus.dm_be, 4'b0000);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int op, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = 1'b1;
    bus.st_op    = 2'(op);
    bus.st_addr  = a;
    bus.st_data  = d;
  endtask

  logic [31:0] popped[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.st_valid = 1'b0;
    bus.st_op    = 2'd0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.dm_ack   = 1'b0;
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("rst_dm_req",    bus.dm_req,    1'b0);
    check("rst_buf_count", bus.buf_count, 0);
    check("rst_st_ready",  bus.st_ready,  1'b1);
    check("rst_buf_empty", bus.buf_empty, 1'b1);
    check("rst_dm_be",     bus.dm_be,     4'b0000);
    check("rst_dm_addr",   bus.dm_addr,   32'h0);
    check("rst_dm_wdata",  bus.dm_wdata,  32'h0);
    check("rst_st_err",    bus.st_err,    1'b0);
    step();
    reset_n = 1'b1;

    // 1: reset with two entries pending
    req(0, 32'h100, 32'h1);
    step();
    req(0, 32'h104, 32'h2);
    step();
    bus.st_valid = 1'b0;
    @(negedge clk);
    check("t1_count_before", bus.buf_count, 2);
    step();
    reset_n = 1'b0;
    @(negedge clk);
    check("t1_dm_req",   bus.dm_req,    1'b0);
    check("t1_count",    bus.buf_count, 0);
    check("t1_st_ready", bus.st_ready,  1'b1);
    step();
    reset_n = 1'b1;

    // 2: byte store
    req(2, 32'h1003, 32'h1234_5678);
    step();
    bus.st_valid = 1'b0;
    @(negedge clk);
    check("t2_dm_addr",  bus.dm_addr,  32'h1000);
    check("t2_dm_wdata", bus.dm_wdata, 32'h7878_7878);
    check("t2_dm_be",    bus.dm_be,    4'b1000);
    bus.dm_ack = 1'b1;
    step();
    bus.dm_ack = 1'b0;

    // 3: half store, then a misaligned half
    req(1, 32'h2002, 32'hAAAA_BEEF);
    step();
    @(negedge clk);
    check("t3_dm_wdata", bus.dm_wdata, 32'hBEEF_BEEF);
    check("t3_dm_be",    bus.dm_be,    4'b1100);
    req(1, 32'h2001, 32'h5555_1234);
    step();
    bus.st_valid = 1'b0;
    @(negedge clk);
    check("t3_st_err",   bus.st_err,    1'b1);
    check("t3_count",    bus.buf_count, 1);
    step();
    @(negedge clk);
    check("t3_st_err_off", bus.st_err, 1'b0);
    bus.dm_ack = 1'b1;
    step();
    bus.dm_ack = 1'b0;

    // 4: fill, hold the third push, then release one slot
    req(0, 32'h3000, 32'hA);
    step();
    req(0, 32'h3004, 32'hB);
    step();
    @(negedge clk);
    check("t4_full_count", bus.buf_count, 2);
    check("t4_full_ready", bus.st_ready,  1'b0);
    req(0, 32'h3008, 32'hC);
    step();
    step();
    @(negedge clk);
    check("t4_held_count", bus.buf_count, 2);
    check("t4_held_head",  bus.dm_addr,   32'h3000);
    bus.dm_ack = 1'b1;
    step();
    bus.dm_ack = 1'b0;
    @(negedge clk);
    check("t4_pop_count", bus.buf_count, 1);
    check("t4_pop_ready", bus.st_ready,  1'b1);
    check("t4_pop_head",  bus.dm_addr,   32'h3004);
    step();
    bus.st_valid = 1'b0;
    @(negedge clk);
    check("t4_refill_count", bus.buf_count, 2);
    bus.dm_ack = 1'b1;
    step();
    @(negedge clk);
    check("t4_head3", bus.dm_addr, 32'h3008);
    check("t4_data3", bus.dm_wdata, 32'hC);
    step();
    bus.dm_ack = 1'b0;
    @(negedge clk);
    check("t4_drained", bus.buf_count, 0);

    // 5: streaming push+pop
    bus.dm_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req(0, 32'h4000 + 32'(4 * i), 32'h1111_1111 * 32'(i));
      step();
      @(negedge clk);
      check("t5_count_le1", bus.buf_count <= 1, 1'b1);
      if (bus.dm_req) popped.push_back(bus.dm_addr);
    end
    bus.st_valid = 1'b0;
    step();
    bus.dm_ack = 1'b0;
    @(negedge clk);
    check("t5_drained", bus.buf_count, 0);
    check("t5_npopped", popped.size(), 8);
    for (int i = 0; i < popped.size(); i++)
      check("t5_order", popped[i], 32'h4000 + 32'(4 * i));

    // 6: reserved op, then dm_ack while empty
    req(3, 32'h0, 32'hDEAD_BEEF);
    step();
    bus.st_valid = 1'b0;
    @(negedge clk);
    check("t6_st_err", bus.st_err,    1'b1);
    check("t6_count",  bus.buf_count, 0);
    check("t6_dm_req", bus.dm_req,    1'b0);
    bus.dm_ack = 1'b1;
    step();
    step();
    @(negedge clk);
    check("t6_ack_count", bus.buf_count, 0);
    check("t6_ack_be",    bus.dm_be,     4'b0000);
    check("t6_ack_req",   bus.dm_req,    1'b0);
    bus.dm_ack = 1'b0;

    // Random traffic against the model, with one reset mid-run
    for (int i = 0; i < 400; i++) begin
      bus.st_valid = ($urandom % 4) != 0;
      bus.st_op    = 2'($urandom % 4);
      bus.st_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom % 4)};
      if (($urandom % 2) == 0) bus.st_addr[1:0] = 2'b00;
      bus.st_data  = $urandom;
      bus.dm_ack   = ($urandom % 2) != 0;
      if (i == 200) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end else begin
        step();
      end
    end
    bus.st_valid = 1'b0;
    bus.dm_ack   = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("rand_drained", bus.buf_empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
